// File: rtl/nco_sample_gen_if.sv
// Control and status bundle for the NCO sample-enable generator.
// The clock-recovery loop drives the master side; the generator is the slave.
interface nco_sample_gen_if #(
    parameter int DIFF_W = 5,
    parameter int CORR_W = 8,
    parameter int IDX_W  = 4
);
    logic                     speed_up;
    logic                     slow_down;
    logic [DIFF_W-1:0]        diff_amt;
    logic                     clear_corr;
    logic                     resync;
    logic                     enb;
    logic [IDX_W-1:0]         sample_idx;
    logic                     bit_tick;
    logic                     mid_tick;
    logic signed [CORR_W-1:0] corr;
    logic                     corr_sat;

    modport master (
        output speed_up, slow_down, diff_amt, clear_corr, resync,
        input  enb, sample_idx, bit_tick, mid_tick, corr, corr_sat
    );

    modport slave (
        input  speed_up, slow_down, diff_amt, clear_corr, resync,
        output enb, sample_idx, bit_tick, mid_tick, corr, corr_sat
    );
endinterface

// File: rtl/nco_sample_gen.sv
// Phase-accumulator sample-enable generator with saturating rate correction,
// phase resync, per-bit sample index and mid/end-of-bit ticks.
module nco_sample_gen #(
    parameter int unsigned CLKFREQ     = 100_000_000,
    parameter int unsigned BAUD        = 50_000,
    parameter int unsigned SAMPLE_FREQ = 16,
    parameter int          ACC_W       = 32,
    parameter int unsigned STEP_HZ     = BAUD / 10,
    parameter int          MAX_STEPS   = 10,
    parameter int          DIFF_W      = 5,
    parameter int          CORR_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    nco_sample_gen_if.slave bus
);
    localparam int IDX_W = $clog2(SAMPLE_FREQ);
    localparam int SUM_W = CORR_W + DIFF_W + 1;

    localparam logic [63:0] NOM_INC64 =
        ((64'(SAMPLE_FREQ) * 64'(BAUD)) << ACC_W) / 64'(CLKFREQ);
    localparam logic [63:0] STEP_INC64 = (64'(STEP_HZ) << ACC_W) / 64'(CLKFREQ);
    localparam logic [ACC_W-1:0] NOM_INC  = NOM_INC64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] STEP_INC = STEP_INC64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] HALF_PHASE = {1'b1, {(ACC_W-1){1'b0}}};

    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_STEPS);
    localparam logic signed [SUM_W-1:0] MIN_S = -MAX_S;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_FREQ - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(SAMPLE_FREQ / 2 - 1);

    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         inc_q;
    logic [ACC_W:0]           sum;
    logic                     enb_q;
    logic                     bit_tick_q;
    logic                     mid_tick_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_inc;
    logic signed [CORR_W-1:0] corr_q;
    logic                     corr_sat_q;

    logic signed [SUM_W-1:0]  corr_ext;
    logic signed [SUM_W-1:0]  diff_ext;
    logic signed [SUM_W-1:0]  corr_sum;
    logic signed [SUM_W-1:0]  corr_nxt;
    logic signed [63:0]       inc_wide;

    // Rate follows the registered correction, so a request reaches the adder two edges later.
    always_comb begin
        inc_wide = $signed({{(64-ACC_W){1'b0}}, NOM_INC})
                 + $signed({{(64-CORR_W){corr_q[CORR_W-1]}}, corr_q})
                 * $signed({{(64-ACC_W){1'b0}}, STEP_INC});
    end

    assign sum     = {1'b0, acc_q} + {1'b0, inc_q};
    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            inc_q      <= NOM_INC;
            enb_q      <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
            idx_q      <= IDX_LAST;
        end else begin
            inc_q <= inc_wide[ACC_W-1:0];
            if (bus.resync) begin
                // Restart mid-sample and drop any carry from this cycle's add.
                acc_q      <= HALF_PHASE;
                enb_q      <= 1'b0;
                bit_tick_q <= 1'b0;
                mid_tick_q <= 1'b0;
                idx_q      <= IDX_LAST;
            end else begin
                acc_q      <= sum[ACC_W-1:0];
                enb_q      <= sum[ACC_W];
                bit_tick_q <= sum[ACC_W] && (idx_inc == IDX_LAST);
                mid_tick_q <= sum[ACC_W] && (idx_inc == IDX_MID);
                if (sum[ACC_W])
                    idx_q <= idx_inc;
            end
        end
    end

    // Sums are wide enough that no request can wrap before the clamp.
    always_comb begin
        corr_ext = $signed({{(SUM_W-CORR_W){corr_q[CORR_W-1]}}, corr_q});
        diff_ext = $signed({{(SUM_W-DIFF_W){1'b0}}, bus.diff_amt});
        corr_sum = corr_ext;
        if (bus.speed_up && !bus.slow_down)
            corr_sum = corr_ext + diff_ext;
        else if (bus.slow_down && !bus.speed_up)
            corr_sum = corr_ext - diff_ext;
        if (corr_sum > MAX_S)
            corr_nxt = MAX_S;
        else if (corr_sum < MIN_S)
            corr_nxt = MIN_S;
        else
            corr_nxt = corr_sum;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear_corr) begin
            corr_q     <= '0;
            corr_sat_q <= 1'b0;
        end else begin
            corr_q     <= corr_nxt[CORR_W-1:0];
            corr_sat_q <= (corr_nxt == MAX_S) || (corr_nxt == MIN_S);
        end
    end

    assign bus.enb        = enb_q;
    assign bus.sample_idx = idx_q;
    assign bus.bit_tick   = bit_tick_q;
    assign bus.mid_tick   = mid_tick_q;
    assign bus.corr       = corr_q;
    assign bus.corr_sat   = corr_sat_q;
endmodule

// File: tb/tb_nco_sample_gen.sv
// Directed bench for nco_sample_gen at default parameters (125.0000013 clk per enb).
module tb_nco_sample_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nco_sample_gen_if #(.DIFF_W(5), .CORR_W(8), .IDX_W(4)) bus ();

    nco_sample_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Steps until enb is seen; n is the number of edges taken (bound reached -> n == bound).
    task automatic wait_enb(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.enb && n < bound);
    endtask

    task automatic run_window(input int n, output int cnt, output int mn,
                              output int mx, output int bad);
        int last;
        cnt = 0; mn = 1_000_000; mx = 0; bad = 0; last = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.enb) begin
                if (last >= 0) begin
                    if (i - last < mn) mn = i - last;
                    if (i - last > mx) mx = i - last;
                end
                last = i;
                cnt++;
            end else if (bus.bit_tick || bus.mid_tick) begin
                bad++;
            end
        end
    endtask

    task automatic pulse(input logic su, input logic sd, input logic cc, input logic [4:0] d);
        bus.speed_up = su; bus.slow_down = sd; bus.clear_corr = cc; bus.diff_amt = d;
        step();
        bus.speed_up = 1'b0; bus.slow_down = 1'b0; bus.clear_corr = 1'b0; bus.diff_amt = '0;
    endtask

    initial begin
        int n, cnt, mn, mx, bad, stray;
        bus.speed_up = 1'b0; bus.slow_down = 1'b0; bus.clear_corr = 1'b0;
        bus.diff_amt = '0;   bus.resync = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_enb", bus.enb, 0);
        check("rst_idx", bus.sample_idx, 15);
        check("rst_corr", bus.corr, 0);
        check("rst_sat", bus.corr_sat, 0);
        check("rst_ticks", {bus.bit_tick, bus.mid_tick}, 0);

        // Free run at nominal rate: k-th enb lands on edge 125k+1
        reset = 1'b0;
        wait_enb(300, n);
        check("first_enb_lat", n, 126);
        check("first_idx", bus.sample_idx, 0);
        for (int k = 2; k <= 16; k++) begin
            wait_enb(300, n);
            check("nom_spacing", n, 125);
            check("nom_idx", bus.sample_idx, k - 1);
            check("mid_tick", bus.mid_tick, (k == 8) ? 1 : 0);
            check("bit_tick", bus.bit_tick, (k == 16) ? 1 : 0);
        end
        run_window(10_000, cnt, mn, mx, bad);
        check_rng("nom_count", cnt, 79, 81);
        check_rng("nom_min_sp", mn, 125, 126);
        check_rng("nom_max_sp", mx, 125, 126);
        check("nom_stray_tick", bad, 0);

        // +10 steps: 2^32/36507218 = 117.65 clk per enb
        pulse(1, 0, 0, 5'd10);
        check("up10_corr", bus.corr, 10);
        check("up10_sat", bus.corr_sat, 1);
        step();
        check("up10_corr_hold", bus.corr, 10);
        run_window(10_000, cnt, mn, mx, bad);
        check_rng("fast_count", cnt, 84, 86);
        check_rng("fast_min_sp", mn, 117, 118);
        check_rng("fast_max_sp", mx, 117, 118);

        // Saturation without wrap, both directions
        pulse(0, 1, 0, 5'd2);
        check("dn2_corr", bus.corr, 8);
        check("dn2_sat", bus.corr_sat, 0);
        pulse(1, 0, 0, 5'd31);
        check("up31_corr", bus.corr, 10);
        check("up31_sat", bus.corr_sat, 1);
        pulse(0, 1, 0, 5'd31);
        check("dn31a_corr", bus.corr, -10);
        pulse(0, 1, 0, 5'd31);
        check("dn31b_corr", bus.corr, -10);
        check("dn31b_sat", bus.corr_sat, 1);
        step();
        run_window(10_000, cnt, mn, mx, bad);
        check_rng("slow_count", cnt, 74, 76);
        check_rng("slow_min_sp", mn, 133, 134);
        check_rng("slow_max_sp", mx, 133, 134);

        // Conflicting / zero requests hold, clear beats requests
        pulse(1, 0, 0, 5'd3);
        check("up3_corr", bus.corr, -7);
        check("up3_sat", bus.corr_sat, 0);
        pulse(1, 1, 0, 5'd5);
        check("both_hold", bus.corr, -7);
        pulse(1, 0, 0, 5'd0);
        check("zero_hold", bus.corr, -7);
        pulse(1, 0, 1, 5'd5);
        check("clear_corr", bus.corr, 0);
        check("clear_sat", bus.corr_sat, 0);

        // Resync on the edge of the 9th enb's carry (edge 1126 after reset)
        reset = 1'b1; step(); reset = 1'b0;
        wait_enb(300, n);
        check("rs_first", n, 126);
        for (int k = 2; k <= 8; k++) wait_enb(300, n);
        check("rs_8th_mid", bus.mid_tick, 1);
        stray = 0;
        for (int i = 0; i < 124; i++) begin
            step();
            if (bus.enb) stray++;
        end
        check("rs_pre_quiet", stray, 0);
        bus.resync = 1'b1;
        step();
        bus.resync = 1'b0;
        check("rs_enb_killed", {bus.enb, bus.bit_tick, bus.mid_tick}, 0);
        wait_enb(300, n);
        check("rs_lat", n, 63);
        check("rs_idx", bus.sample_idx, 0);
        wait_enb(300, n);
        check_rng("rs_spacing", n, 125, 126);
        check("rs_idx_next", bus.sample_idx, 1);

        // corr=+4 from edge 1: first carry would come on edge 123; reset that edge
        reset = 1'b1; step(); reset = 1'b0;
        pulse(1, 0, 0, 5'd4);
        check("r4_corr", bus.corr, 4);
        stray = 0;
        for (int i = 0; i < 121; i++) begin
            step();
            if (bus.enb) stray++;
        end
        check("r4_pre_quiet", stray, 0);
        reset = 1'b1;
        step();
        check("r4_no_enb", bus.enb, 0);
        check("r4_corr_clr", bus.corr, 0);
        check("r4_idx", bus.sample_idx, 15);
        reset = 1'b0;
        wait_enb(300, n);
        check("r4_relat", n, 126);
        check("r4_reidx", bus.sample_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
